imem_line_buffer: RTL and testbench

IMEM_LINE_BUFFER -- requirements
Module: imem_line_buffer

---
 rtl/imem_line_buffer.sv | 140 ++++++++++++++
 tb/tb_imem_line_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_line_buffer.sv
// Single-line instruction buffer between the CPU fetch port and a 64-bit
// backing memory. Holds one 32-byte line (8 words), filled by 4 beats,
// and answers hits with one-cycle latency.
module imem_line_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic        inv,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  input  logic        bmem_ready,
  input  logic [63:0] bmem_rdata,
  input  logic        bmem_rvalid
);

  typedef enum logic [1:0] {IDLE, RESP, MISS_REQ, MISS_FILL} state_t;

  state_t      state_reg, state_next;
  logic [29:0] addr_reg, addr_next;         // latched word address (byte addr [31:2])
  logic [26:0] tag_reg, tag_next;
  logic        valid_reg, valid_next;
  logic        inv_pend_reg, inv_pend_next; // invalidate seen while a fill is in flight
  logic [1:0]  beat_reg, beat_next;
  logic [31:0] rdata_hold_reg;
  logic        fill_we;
  logic        req;
  logic        hit;
  logic [31:0] resp_word;
  logic [31:0] line_mem [8];
  logic        unused_addr_bits;

  // Byte offset inside a word is irrelevant for instruction fetch.
  assign unused_addr_bits = ^imem_addr[1:0];

  assign req       = |imem_rmask;
  assign hit       = valid_reg && (tag_reg == imem_addr[31:5]) && !inv;
  assign resp_word = line_mem[addr_reg[2:0]];

  // Outputs are pure functions of registered state, so no input-to-output paths.
  assign imem_resp  = (state_reg == RESP);
  assign imem_rdata = imem_resp ? resp_word : rdata_hold_reg;
  assign bmem_read  = (state_reg == MISS_REQ);
  assign bmem_addr  = bmem_read ? {addr_reg[29:3], 5'b0} : 32'h0;

  // Next-state logic: request acceptance, miss handshake and fill sequencing.
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    tag_next      = tag_reg;
    valid_next    = valid_reg;
    inv_pend_next = inv_pend_reg;
    beat_next     = beat_reg;
    fill_we       = 1'b0;
    case (state_reg)
      IDLE, RESP: begin
        if (inv) begin
          valid_next = 1'b0;
        end
        if (req) begin
          addr_next     = imem_addr[31:2];
          inv_pend_next = 1'b0;
          if (hit) begin
            state_next = RESP;
          end else begin
            // The line is about to be overwritten, so it stops being valid now.
            state_next = MISS_REQ;
            valid_next = 1'b0;
          end
        end else begin
          state_next = IDLE;
        end
      end
      MISS_REQ: begin
        if (inv) begin
          inv_pend_next = 1'b1;
        end
        if (bmem_ready) begin
          state_next = MISS_FILL;
          beat_next  = 2'd0;
        end
      end
      MISS_FILL: begin
        if (inv) begin
          inv_pend_next = 1'b1;
        end
        if (bmem_rvalid) begin
          fill_we   = 1'b1;
          beat_next = beat_reg + 2'd1;
          if (beat_reg == 2'd3) begin
            // Deliver the word either way, but drop the line if invalidated mid-fill.
            state_next = RESP;
            tag_next   = addr_reg[29:3];
            valid_next = !(inv_pend_reg || inv);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      tag_reg      <= '0;
      valid_reg    <= 1'b0;
      inv_pend_reg <= 1'b0;
      beat_reg     <= 2'd0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      tag_reg      <= tag_next;
      valid_reg    <= valid_next;
      inv_pend_reg <= inv_pend_next;
      beat_reg     <= beat_next;
    end
  end

  // Remember the last delivered word so imem_rdata holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_hold_reg <= '0;
    end else if (state_reg == RESP) begin
      rdata_hold_reg <= resp_word;
    end
  end

  // Line storage: each fill beat writes an even/odd word pair; contents are not reset.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      line_mem[{beat_reg, 1'b0}] <= bmem_rdata[31:0];
      line_mem[{beat_reg, 1'b1}] <= bmem_rdata[63:32];
    end
  end

endmodule

// File: tb/tb_imem_line_buffer.sv
// Self-checking bench for imem_line_buffer: directed scenarios plus randomized
// fetches, checked against a line-level reference (tag/valid + memory image).
module tb_imem_line_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr = '0;
  logic [3:0]  imem_rmask = '0;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        inv = 1'b0;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_ready = 1'b0;
  logic [63:0] bmem_rdata = '0;
  logic        bmem_rvalid = 1'b0;

  int checks = 0;
  int failures = 0;

  // Reference model: which line the buffer should be holding.
  logic        m_valid = 1'b0;
  logic [26:0] m_tag = '0;

  imem_line_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_rmask  (imem_rmask),
    .imem_rdata  (imem_rdata),
    .imem_resp   (imem_resp),
    .inv         (inv),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_ready  (bmem_ready),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Backing memory image; line 0x100 carries the 0x11..0x44 beat patterns.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    logic [7:0]  b;
    int          kk;
    w = {a[31:2], 2'b00};
    if (w[31:5] == 27'h8) begin
      kk = int'(w[4:3]) + 1;
      b  = 8'(8'h11 * kk);
      return w[2] ? ({4{b}} ^ 32'hFFFF_0000) : {4{b}};
    end
    return (w * 32'h9E37_79B1) ^ {w[15:0], w[31:16]};
  endfunction

  function automatic logic [63:0] beat_data(input logic [31:0] base, input int k);
    return {mem_word(base + 32'(8 * k + 4)), mem_word(base + 32'(8 * k))};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One fetch transaction, acting as the backing memory when a fill is requested.
  task automatic fetch(input logic [31:0] a, input bit inv_req, input bit inv_mid,
                       input int wait_n, input int gap_max, input bit stray);
    bit          miss, got, hs, inv_done;
    int          cyc, rd_cnt, beats, wl, gl, gaps;
    logic [31:0] base;
    miss = inv_req || !m_valid || (m_tag != a[31:5]);
    base = {a[31:5], 5'b0};
    imem_addr  = a;
    imem_rmask = 4'($urandom_range(1, 15));
    inv        = inv_req;
    @(negedge clk);
    got = 0; hs = 0; inv_done = 0; cyc = 0; rd_cnt = 0; beats = 0;
    wl = wait_n; gl = 0; gaps = 0;
    while (!got && cyc < 300) begin
      imem_rmask = 4'h0; inv = 1'b0; bmem_ready = 1'b0; bmem_rvalid = 1'b0;
      if (imem_resp) begin
        got = 1;
        check("resp_data", imem_rdata, mem_word(a));
        check("resp_latency", 32'(cyc), miss ? 32'(5 + wait_n + gaps) : 32'd0);
      end else if (bmem_read) begin
        rd_cnt++;
        check("bmem_addr", bmem_addr, base);
        if (stray) begin
          bmem_rvalid = 1'b1;
          bmem_rdata  = {$urandom, $urandom};
        end
        if (wl == 0) begin
          bmem_ready = 1'b1;
          hs = 1;
          gl = $urandom_range(0, gap_max);
        end else begin
          wl--;
        end
      end else if (hs && beats < 4) begin
        if (stray) begin
          imem_rmask = 4'hF;
          imem_addr  = $urandom;
        end
        if (inv_mid && beats == 1 && !inv_done) begin
          inv = 1'b1;
          inv_done = 1;
        end
        if (gl > 0) begin
          gl--;
          gaps++;
        end else begin
          bmem_rvalid = 1'b1;
          bmem_rdata  = beat_data(base, beats);
          beats++;
          gl = $urandom_range(0, gap_max);
        end
      end
      if (!got) begin
        @(negedge clk);
        cyc++;
      end
    end
    imem_rmask = 4'h0; inv = 1'b0; bmem_ready = 1'b0; bmem_rvalid = 1'b0;
    check("resp_seen", 32'(got), 32'd1);
    check("bmem_read_cycles", 32'(rd_cnt), miss ? 32'(wait_n + 1) : 32'd0);
    if (miss) begin
      m_tag   = a[31:5];
      m_valid = !inv_mid;
    end
    @(negedge clk);
    check("resp_single_pulse", 32'(imem_resp), 32'd0);
    check("rdata_hold", imem_rdata, mem_word(a));
    $display("fetch addr=%h miss=%0d inv_req=%0d inv_mid=%0d wait=%0d gaps=%0d rdata=%h",
             a, miss, inv_req, inv_mid, wait_n, gaps, imem_rdata);
  endtask

  initial begin
    logic [31:0] a;
    // Reset state
    #3;
    check("reset_resp", 32'(imem_resp), 32'd0);
    check("reset_rdata", imem_rdata, 32'd0);
    check("reset_bmem_read", 32'(bmem_read), 32'd0);
    check("reset_bmem_addr", bmem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold miss on 0x104, zero wait states
    fetch(32'h0000_0104, 0, 0, 0, 0, 0);

    // Hit streaming across the whole line, one request per cycle
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        check("stream_resp", 32'(imem_resp), 32'd1);
        check("stream_data", imem_rdata, mem_word(32'h100 + 32'(4 * (i - 1))));
        check("stream_bmem_read", 32'(bmem_read), 32'd0);
      end
      if (i < 8) begin
        imem_addr  = 32'h100 + 32'(4 * i);
        imem_rmask = 4'hF;
      end else begin
        imem_rmask = 4'h0;
      end
      @(negedge clk);
    end
    check("stream_end_resp", 32'(imem_resp), 32'd0);
    $display("stream line=00000100 words=8");

    // Miss with ready wait states and beat gaps
    fetch(32'h4000_0a18, 0, 0, 3, 2, 0);

    // Invalidate mid-fill, then re-request the same line
    fetch(32'h0000_0208, 0, 1, 1, 1, 0);
    fetch(32'h0000_020c, 0, 0, 0, 0, 0);

    // Stray rvalid while idle must change nothing
    for (int i = 0; i < 3; i++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = {$urandom, $urandom};
      @(negedge clk);
      check("stray_idle_resp", 32'(imem_resp), 32'd0);
      check("stray_idle_read", 32'(bmem_read), 32'd0);
    end
    bmem_rvalid = 1'b0;
    $display("stray rvalid in idle x3");
    fetch(32'h0000_0200, 0, 0, 0, 0, 0);

    // Stray rvalid during miss request and rmask during fill
    fetch(32'h0000_0300, 0, 0, 2, 1, 1);
    fetch(32'h0000_031c, 0, 0, 0, 0, 0);

    // inv while idle, then request: must miss; inv with request: forced miss
    inv = 1'b1;
    @(negedge clk);
    inv = 1'b0;
    m_valid = 1'b0;
    fetch(32'h0000_0304, 0, 0, 0, 0, 0);
    fetch(32'h0000_0308, 1, 0, 1, 0, 0);
    fetch(32'h0000_0310, 0, 0, 0, 0, 0);

    // Randomized fetches over a few lines
    for (int n = 0; n < 40; n++) begin
      a = 32'h0000_1000 + 32'($urandom_range(0, 2) << 5) + 32'($urandom_range(0, 7) << 2)
          + 32'($urandom_range(0, 3));
      fetch(a, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3) == 0);
    end

    // Asynchronous reset during beat 2 of a fill
    a = 32'h2000_0044;
    imem_addr  = a;
    imem_rmask = 4'hF;
    @(negedge clk);
    imem_rmask = 4'h0;
    bmem_ready = 1'b1;
    @(negedge clk);
    bmem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = beat_data({a[31:5], 5'b0}, k);
      @(negedge clk);
    end
    bmem_rdata = beat_data({a[31:5], 5'b0}, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_resp", 32'(imem_resp), 32'd0);
    check("async_rst_read", 32'(bmem_read), 32'd0);
    check("async_rst_rdata", imem_rdata, 32'd0);
    check("async_rst_addr", bmem_addr, 32'd0);
    m_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 2; k < 4; k++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = beat_data({a[31:5], 5'b0}, k);
      @(negedge clk);
      check("post_rst_resp", 32'(imem_resp), 32'd0);
      check("post_rst_read", 32'(bmem_read), 32'd0);
    end
    bmem_rvalid = 1'b0;
    $display("async reset during beat 2, late beats ignored");
    fetch(a, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
